// File: rtl/crc_seq_pkg.sv
// Shared types and helpers for the CRC datapath sequencer: FSM state
// encoding, bus size encodings and the bytes-per-transfer lookup.
package crc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        RST  = 2'd2
    } state_t;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'b00;
    localparam logic [1:0] BUS_SIZE_HALF = 2'b01;
    localparam logic [1:0] BUS_SIZE_WORD = 2'b10;
    localparam logic [1:0] BUS_SIZE_RSVD = 2'b11;

    // One FIFO entry holds the captured size above the 32-bit data word.
    localparam int ENTRY_W = 34;

    // Number of bytes to feed for a given bus size; reserved behaves as a word.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            BUS_SIZE_BYTE: nbytes = 3'd1;
            BUS_SIZE_HALF: nbytes = 3'd2;
            default:       nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/crc_datapath_sequencer_if.sv
// Host-side write/control signals, flow-control feedback and the byte
// stream towards the CRC unit, bundled for the sequencer port list.
interface crc_datapath_sequencer_if;

    logic        buffer_write_en;
    logic [31:0] bus_wr;
    logic [1:0]  bus_size;
    logic        reset_chain;

    logic        buffer_full;
    logic        read_wait;
    logic        reset_pending;

    logic        crc_unit_en;
    logic [7:0]  data_byte;
    logic        last_byte;
    logic        crc_load_init;

    modport master (
        output buffer_write_en, bus_wr, bus_size, reset_chain,
        input  buffer_full, read_wait, reset_pending,
        input  crc_unit_en, data_byte, last_byte, crc_load_init
    );

    modport slave (
        input  buffer_write_en, bus_wr, bus_size, reset_chain,
        output buffer_full, read_wait, reset_pending,
        output crc_unit_en, data_byte, last_byte, crc_load_init
    );

endinterface

// File: rtl/crc_in_fifo.sv
// Small synchronous FIFO buffering host words ahead of the CRC byte feeder.
// Push while full is only accepted when a pop frees the slot in the same
// cycle; flush empties the FIFO and wins over push and pop.
module crc_in_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next pointer/count/storage values; pointers wrap naturally for power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/crc_datapath_sequencer.sv
// Buffers host words for the CRC unit and feeds them one byte per cycle,
// LSB first, according to the size captured with each word. A chain reset
// aborts the current word, flushes the buffer and pulses crc_load_init.
module crc_datapath_sequencer
    import crc_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    crc_datapath_sequencer_if.slave   bus
);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] work_q, work_d;
    logic [1:0]  size_q, size_d;

    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          fifo_flush;
    logic [ENTRY_W-1:0]            fifo_rdata;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    logic       crc_unit_en;
    logic [7:0] data_byte;
    logic       last_byte;
    logic       crc_load_init;
    logic       reset_pending;
    logic       is_last;

    crc_in_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata ({bus.bus_size, bus.bus_wr}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign is_last = ({1'b0, byte_cnt_q} == (nbytes(size_q) - 3'd1));

    // Next-state, byte feeding and FIFO control; chain reset outranks pop, pop outranks push.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        work_d        = work_q;
        size_d        = size_q;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        crc_unit_en   = 1'b0;
        data_byte     = '0;
        last_byte     = 1'b0;
        crc_load_init = 1'b0;
        reset_pending = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.reset_chain) begin
                    state_d = RST;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    work_d     = fifo_rdata[31:0];
                    size_d     = fifo_rdata[33:32];
                    byte_cnt_d = '0;
                    state_d    = PROC;
                end
            end
            PROC: begin
                crc_unit_en = 1'b1;
                data_byte   = work_q[{byte_cnt_q, 3'b000} +: 8];
                last_byte   = is_last;
                if (bus.reset_chain) begin
                    state_d = RST;
                end else if (!is_last) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    work_d     = fifo_rdata[31:0];
                    size_d     = fifo_rdata[33:32];
                    byte_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RST: begin
                crc_load_init = 1'b1;
                reset_pending = 1'b1;
                fifo_flush    = 1'b1;
                byte_cnt_d    = '0;
                state_d       = bus.reset_chain ? RST : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fifo_push = bus.buffer_write_en && !bus.reset_chain && (state_q != RST) &&
                    (!fifo_full || fifo_pop);
    end

    // Sequencer registers; HRESET clears everything without a load-init pulse.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            work_q     <= '0;
            size_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            work_q     <= work_d;
            size_q     <= size_d;
        end
    end

    assign bus.crc_unit_en   = crc_unit_en;
    assign bus.data_byte     = data_byte;
    assign bus.last_byte     = last_byte;
    assign bus.crc_load_init = crc_load_init;
    assign bus.reset_pending = reset_pending;
    assign bus.buffer_full   = fifo_full;
    assign bus.read_wait     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_crc_datapath_sequencer.sv
// Testbench for crc_datapath_sequencer: directed scenarios plus random word
// traffic, with a byte-stream scoreboard checked by an independent monitor.
module tb_crc_datapath_sequencer;

    logic HCLK = 1'b0;
    logic HRESET;

    crc_datapath_sequencer_if bus ();

    crc_datapath_sequencer #(
        .FIFO_DEPTH (2)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    // 100 MHz clock.
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int modelBytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    // Queue the first 'keep' bytes the CRC unit should see for this word.
    task automatic expectWord(input logic [31:0] w, input logic [1:0] sz, input int keep);
        int n;
        n = modelBytes(sz);
        for (int k = 0; k < keep; k++) begin
            exp_t e;
            e.b    = 8'((w >> (8 * k)) & 32'hFF);
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    // Hold the given inputs for one rising edge, then return them to idle.
    task automatic applyStimulus(input logic we, input logic [31:0] d,
                                 input logic [1:0] sz, input logic rc);
        bus.buffer_write_en = we;
        bus.bus_wr          = d;
        bus.bus_size        = sz;
        bus.reset_chain     = rc;
        @(posedge HCLK);
        #1;
        bus.buffer_write_en = 1'b0;
        bus.bus_wr          = '0;
        bus.bus_size        = '0;
        bus.reset_chain     = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (!bus.read_wait) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput({name, "_drain"}, 32'(done), 32'd1);
        checkOutput({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: every byte the CRC unit consumes must match the scoreboard head.
    always @(negedge HCLK) begin
        if (!HRESET && bus.crc_unit_en) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", bus.data_byte);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_data", 32'(bus.data_byte), 32'(mon_e.b));
                checkOutput("sb_last", 32'(bus.last_byte), 32'(mon_e.last));
            end
        end
    end

    // Bound the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  sz;

        bus.buffer_write_en = 1'b0;
        bus.bus_wr          = '0;
        bus.bus_size        = '0;
        bus.reset_chain     = 1'b0;
        HRESET              = 1'b1;

        // Reset state
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("rst_full",    32'(bus.buffer_full),   32'd0);
        checkOutput("rst_wait",    32'(bus.read_wait),     32'd0);
        checkOutput("rst_pending", 32'(bus.reset_pending), 32'd0);
        checkOutput("rst_en",      32'(bus.crc_unit_en),   32'd0);
        checkOutput("rst_data",    32'(bus.data_byte),     32'd0);
        checkOutput("rst_last",    32'(bus.last_byte),     32'd0);
        checkOutput("rst_init",    32'(bus.crc_load_init), 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Test 1: single word, latency and read_wait window
        $display("[TB] test 1: single word");
        expectWord(32'hDDCCBBAA, 2'b10, 4);
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'b10, 1'b0);
        @(negedge HCLK);
        checkOutput("t1_wait_n1", 32'(bus.read_wait),   32'd1);
        checkOutput("t1_en_n1",   32'(bus.crc_unit_en), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            checkOutput("t1_en",   32'(bus.crc_unit_en), 32'd1);
            checkOutput("t1_last", 32'(bus.last_byte),   32'(k == 3));
            checkOutput("t1_wait", 32'(bus.read_wait),   32'd1);
        end
        @(negedge HCLK);
        checkOutput("t1_wait_done", 32'(bus.read_wait),   32'd0);
        checkOutput("t1_en_done",   32'(bus.crc_unit_en), 32'd0);
        @(posedge HCLK);
        #1;

        // Test 2: half then byte, back-to-back with no bubble
        $display("[TB] test 2: back-to-back half and byte");
        expectWord(32'h00001234, 2'b01, 2);
        expectWord(32'h00000056, 2'b00, 1);
        applyStimulus(1'b1, 32'h00001234, 2'b01, 1'b0);
        applyStimulus(1'b1, 32'h00000056, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            checkOutput("t2_en",   32'(bus.crc_unit_en), 32'd1);
            checkOutput("t2_last", 32'(bus.last_byte),   32'(k != 0));
        end
        @(negedge HCLK);
        checkOutput("t2_en_done",   32'(bus.crc_unit_en), 32'd0);
        checkOutput("t2_wait_done", 32'(bus.read_wait),   32'd0);
        @(posedge HCLK);
        #1;

        // Test 3: fill, drop while full, push+pop while full
        $display("[TB] test 3: full handling");
        expectWord(32'hA3A2A1A0, 2'b10, 4);
        expectWord(32'hB3B2B1B0, 2'b10, 4);
        expectWord(32'hC3C2C1C0, 2'b10, 4);
        expectWord(32'hE3E2E1E0, 2'b10, 4);
        applyStimulus(1'b1, 32'hA3A2A1A0, 2'b10, 1'b0);
        applyStimulus(1'b1, 32'hB3B2B1B0, 2'b10, 1'b0);
        applyStimulus(1'b1, 32'hC3C2C1C0, 2'b10, 1'b0);
        @(negedge HCLK);
        checkOutput("t3_full_two", 32'(bus.buffer_full), 32'd1);
        applyStimulus(1'b1, 32'hD3D2D1D0, 2'b10, 1'b0);
        @(negedge HCLK);
        checkOutput("t3_full_drop", 32'(bus.buffer_full), 32'd1);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
        @(negedge HCLK);
        checkOutput("t3_last_a", 32'(bus.last_byte), 32'd1);
        applyStimulus(1'b1, 32'hE3E2E1E0, 2'b10, 1'b0);
        @(negedge HCLK);
        checkOutput("t3_full_pushpop", 32'(bus.buffer_full), 32'd1);
        waitDrain("t3");

        // Test 4: chain reset during the second byte with one word queued
        $display("[TB] test 4: chain reset mid-word");
        expectWord(32'h44332211, 2'b10, 2);
        applyStimulus(1'b1, 32'h44332211, 2'b10, 1'b0);
        applyStimulus(1'b1, 32'h88776655, 2'b10, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge HCLK);
        checkOutput("t4_init",    32'(bus.crc_load_init), 32'd1);
        checkOutput("t4_pending", 32'(bus.reset_pending), 32'd1);
        checkOutput("t4_en_rst",  32'(bus.crc_unit_en),   32'd0);
        @(negedge HCLK);
        checkOutput("t4_init_off",    32'(bus.crc_load_init), 32'd0);
        checkOutput("t4_pending_off", 32'(bus.reset_pending), 32'd0);
        checkOutput("t4_wait",        32'(bus.read_wait),     32'd0);
        checkOutput("t4_full",        32'(bus.buffer_full),   32'd0);
        repeat (6) @(negedge HCLK);
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge HCLK);
        #1;

        // Test 5: write with chain reset from IDLE, then repeated chain reset
        $display("[TB] test 5: write discarded by chain reset");
        applyStimulus(1'b1, 32'hCAFEF00D, 2'b10, 1'b1);
        @(negedge HCLK);
        checkOutput("t5_init",    32'(bus.crc_load_init), 32'd1);
        checkOutput("t5_pending", 32'(bus.reset_pending), 32'd1);
        applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge HCLK);
        checkOutput("t5_pending_again", 32'(bus.reset_pending), 32'd1);
        @(negedge HCLK);
        checkOutput("t5_pending_off", 32'(bus.reset_pending), 32'd0);
        checkOutput("t5_init_off",    32'(bus.crc_load_init), 32'd0);
        repeat (6) @(negedge HCLK);
        checkOutput("t5_wait",     32'(bus.read_wait), 32'd0);
        checkOutput("t5_sb_empty", 32'(sb.size()),     32'd0);
        @(posedge HCLK);
        #1;

        // Test 6: HRESET mid-word with one word queued
        $display("[TB] test 6: async reset mid-word");
        expectWord(32'h0BADBEEF, 2'b10, 1);
        applyStimulus(1'b1, 32'h0BADBEEF, 2'b10, 1'b0);
        applyStimulus(1'b1, 32'h12345678, 2'b10, 1'b0);
        @(negedge HCLK);
        checkOutput("t6_active", 32'(bus.crc_unit_en), 32'd1);
        #1;
        HRESET = 1'b1;
        #1;
        checkOutput("t6_en",      32'(bus.crc_unit_en),   32'd0);
        checkOutput("t6_data",    32'(bus.data_byte),     32'd0);
        checkOutput("t6_last",    32'(bus.last_byte),     32'd0);
        checkOutput("t6_wait",    32'(bus.read_wait),     32'd0);
        checkOutput("t6_full",    32'(bus.buffer_full),   32'd0);
        checkOutput("t6_init",    32'(bus.crc_load_init), 32'd0);
        checkOutput("t6_pending", 32'(bus.reset_pending), 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("t6_wait_after", 32'(bus.read_wait),   32'd0);
        checkOutput("t6_en_after",   32'(bus.crc_unit_en), 32'd0);
        @(posedge HCLK);
        #1;
        expectWord(32'h00000042, 2'b00, 1);
        applyStimulus(1'b1, 32'h00000042, 2'b00, 1'b0);
        waitDrain("t6");

        // Random traffic: push only when the host sees room
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if (!bus.buffer_full && ($urandom_range(0, 99) < 55)) begin
                w  = $urandom;
                sz = 2'($urandom_range(0, 3));
                expectWord(w, sz, modelBytes(sz));
                applyStimulus(1'b1, w, sz, 1'b0);
            end else begin
                applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
            end
        end
        waitDrain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
